// File: rtl/btn_cmd_arbiter_pkg.sv
// Shared types for the button command arbiter: debounce FSM state encoding,
// command codes and channel indices into the {CLR,DN,UP} vectors.
package btn_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_PRESS_WAIT = 2'b01,
    ST_HELD       = 2'b10,
    ST_REL_WAIT   = 2'b11
  } db_state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DN   = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_e;

  localparam int unsigned CH_UP  = 0;
  localparam int unsigned CH_DN  = 1;
  localparam int unsigned CH_CLR = 2;

endpackage

// File: rtl/btn_cmd_arbiter_if.sv
// Button/control inputs and count/status outputs of the arbiter.
// master drives buttons and EN; slave is the arbiter itself.
interface btn_cmd_arbiter_if #(
  parameter int unsigned VAL_W = 14
);
  logic             EN;
  logic             BTN_UP;
  logic             BTN_DN;
  logic             BTN_CLR;
  logic [VAL_W-1:0] VALUE;
  logic             CMD_VALID;
  logic [1:0]       CMD;
  logic [2:0]       BTN_LVL;
  logic             BUSY;

  modport master (
    output EN, BTN_UP, BTN_DN, BTN_CLR,
    input  VALUE, CMD_VALID, CMD, BTN_LVL, BUSY
  );

  modport slave (
    input  EN, BTN_UP, BTN_DN, BTN_CLR,
    output VALUE, CMD_VALID, CMD, BTN_LVL, BUSY
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: 2-flop synchroniser, press/release debounce
// FSM with an up-counting stability timer, debounced level and a one-cycle
// press strobe asserted on the edge that enters HELD.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | button released and stable
//   PRESS_WAIT  | input high, counting stable cycles before accepting press
//   HELD        | press accepted, button held
//   REL_WAIT    | input low, counting stable cycles before accepting release
module btn_debounce_ch #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic lvl_o,
  output logic press_o
);
  import btn_cmd_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchroniser for the raw asynchronous button.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn_i};
  end

  assign s = sync_q[1];

  // FSM state and stability counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and press strobe; the strobe is combinational so the
  // pending flag upstream sets on the same edge the FSM enters HELD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_REL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_REL_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign lvl_o = (state_q == ST_HELD) || (state_q == ST_REL_WAIT);

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Three independently debounced buttons feeding per-channel pending flags,
// a fixed-priority (CLR > DN > UP) single-grant arbiter and a wrapping
// 0..MAX_VAL counter. Pending flags saturate, so repeated presses while
// grants are frozen collapse into one command.
module btn_cmd_arbiter #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned MAX_VAL   = 9999,
  parameter int unsigned VAL_W     = 14
) (
  input logic              CLK,
  input logic              RST,
  btn_cmd_arbiter_if.slave bus
);
  import btn_cmd_pkg::*;

  localparam logic [VAL_W-1:0] MAX_L = VAL_W'(MAX_VAL);

  logic [2:0]       raw;
  logic [2:0]       lvl;
  logic [2:0]       press;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       grant;
  logic [VAL_W-1:0] value_q, value_d;
  logic             cmd_valid_q, cmd_valid_d;
  cmd_e             cmd_q, cmd_d;

  assign raw = {bus.BTN_CLR, bus.BTN_DN, bus.BTN_UP};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .btn_i   (raw[i]),
      .lvl_o   (lvl[i]),
      .press_o (press[i])
    );
  end

  // Priority grant, counter arithmetic and pending-flag update.
  always_comb begin
    grant   = 3'b000;
    cmd_d   = CMD_NONE;
    value_d = value_q;
    if (bus.EN) begin
      if (pending_q[CH_CLR]) begin
        grant[CH_CLR] = 1'b1;
        cmd_d         = CMD_CLR;
      end else if (pending_q[CH_DN]) begin
        grant[CH_DN] = 1'b1;
        cmd_d        = CMD_DN;
      end else if (pending_q[CH_UP]) begin
        grant[CH_UP] = 1'b1;
        cmd_d        = CMD_UP;
      end
    end
    unique case (cmd_d)
      CMD_UP:  value_d = (value_q == MAX_L) ? '0 : value_q + 1'b1;
      CMD_DN:  value_d = (value_q == '0) ? MAX_L : value_q - 1'b1;
      CMD_CLR: value_d = '0;
      default: value_d = value_q;
    endcase
    cmd_valid_d = (cmd_d != CMD_NONE);
    // A fresh press on the grant edge re-arms the flag rather than being lost.
    pending_d   = (pending_q & ~grant) | press;
  end

  // Pending flags, count and registered command outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q   <= 3'b000;
      value_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      pending_q   <= pending_d;
      value_q     <= value_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.VALUE     = value_q;
  assign bus.CMD_VALID = cmd_valid_q;
  assign bus.CMD       = cmd_q;
  assign bus.BTN_LVL   = lvl;
  assign bus.BUSY      = |pending_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter with a short debounce window.
module tb_btn_cmd_arbiter;

  localparam int unsigned DB_CYCLES = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_VAL   = 9999;
  localparam int unsigned VAL_W     = 14;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   cyc;

  logic [1:0]       cmd_log[$];
  int               cyc_log[$];
  logic [VAL_W-1:0] val_log[$];

  btn_cmd_arbiter_if #(.VAL_W(VAL_W)) bus ();

  btn_cmd_arbiter #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W),
    .MAX_VAL   (MAX_VAL),
    .VAL_W     (VAL_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // Log every command pulse with the cycle it was observed in.
  always @(negedge CLK) begin
    if (!RST && bus.CMD_VALID) begin
      cmd_log.push_back(bus.CMD);
      cyc_log.push_back(cyc);
      val_log.push_back(bus.VALUE);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_log();
    cmd_log.delete();
    cyc_log.delete();
    val_log.delete();
  endtask

  task automatic set_btns(input logic [2:0] m);
    bus.BTN_UP  = m[0];
    bus.BTN_DN  = m[1];
    bus.BTN_CLR = m[2];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Full press: held long enough to be accepted, then fully released.
  task automatic press(input logic [2:0] m);
    @(negedge CLK);
    set_btns(m);
    idle(14);
    set_btns(3'b000);
    idle(16);
  endtask

  task automatic pulse_rst();
    @(negedge CLK);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(1);
  endtask

  int t0;
  int lvl_seen;

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    bus.EN = 1'b1;
    set_btns(3'b000);
    idle(3);
    RST = 1'b0;
    idle(1);

    // Reset state
    check("rst_value", bus.VALUE, 0);
    check("rst_cmd_valid", bus.CMD_VALID, 0);
    check("rst_cmd", bus.CMD, 0);
    check("rst_btn_lvl", bus.BTN_LVL, 0);
    check("rst_busy", bus.BUSY, 0);

    // 1: UP held 20 cycles -> single grant 11 cycles after first sample
    clear_log();
    @(negedge CLK);
    t0 = cyc + 1;
    bus.BTN_UP = 1'b1;
    idle(20);
    check("t1_lvl_held", bus.BTN_LVL, 3'b001);
    bus.BTN_UP = 1'b0;
    idle(20);
    check("t1_n_cmds", cmd_log.size(), 1);
    if (cmd_log.size() >= 1) begin
      check("t1_cmd", cmd_log[0], 2'b01);
      check("t1_latency", cyc_log[0] - t0, 11);
    end
    check("t1_value", bus.VALUE, 1);
    check("t1_lvl_rel", bus.BTN_LVL, 0);

    // 2: glitchy UP (3 high / 3 low) -> nothing accepted
    clear_log();
    lvl_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.BTN_LVL != 3'b000) lvl_seen = 1;
      bus.BTN_UP = ((i / 3) % 2 == 0);
    end
    bus.BTN_UP = 1'b0;
    idle(12);
    check("t2_n_cmds", cmd_log.size(), 0);
    check("t2_lvl_seen", lvl_seen, 0);
    check("t2_value", bus.VALUE, 1);

    // 3: bring VALUE to 5, then all three at once -> CLR, DN, UP back to back
    repeat (4) press(3'b001);
    check("t3_value_pre", bus.VALUE, 5);
    clear_log();
    press(3'b111);
    check("t3_n_cmds", cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      check("t3_cmd0", cmd_log[0], 2'b11);
      check("t3_cmd1", cmd_log[1], 2'b10);
      check("t3_cmd2", cmd_log[2], 2'b01);
      check("t3_val0", val_log[0], 0);
      check("t3_val1", val_log[1], 9999);
      check("t3_val2", val_log[2], 0);
      check("t3_gap01", cyc_log[1] - cyc_log[0], 1);
      check("t3_gap12", cyc_log[2] - cyc_log[1], 1);
    end
    check("t3_busy", bus.BUSY, 0);

    // 4: wrap-around both directions
    press(3'b010);
    check("t4_dn_from0", bus.VALUE, 9999);
    press(3'b001);
    check("t4_up_from_max", bus.VALUE, 0);
    press(3'b010);
    check("t4_dn_wrap", bus.VALUE, 9999);

    // 5: EN=0, two DN presses collapse to one grant
    clear_log();
    bus.EN = 1'b0;
    press(3'b010);
    press(3'b010);
    check("t5_busy", bus.BUSY, 1);
    check("t5_value_hold", bus.VALUE, 9999);
    check("t5_no_cmds", cmd_log.size(), 0);
    bus.EN = 1'b1;
    idle(5);
    check("t5_n_cmds", cmd_log.size(), 1);
    if (cmd_log.size() >= 1) check("t5_cmd", cmd_log[0], 2'b10);
    check("t5_value", bus.VALUE, 9998);
    check("t5_busy_after", bus.BUSY, 0);

    // 6a: reset while in PRESS_WAIT
    clear_log();
    @(negedge CLK);
    bus.BTN_UP = 1'b1;
    idle(6);
    bus.BTN_UP = 1'b0;
    pulse_rst();
    check("t6_value", bus.VALUE, 0);
    check("t6_lvl", bus.BTN_LVL, 0);
    check("t6_busy", bus.BUSY, 0);
    idle(20);
    check("t6_no_cmd_a", cmd_log.size(), 0);

    // 6b: reset with a pending flag set
    bus.EN = 1'b0;
    press(3'b001);
    check("t6_busy_pend", bus.BUSY, 1);
    pulse_rst();
    check("t6_busy_cleared", bus.BUSY, 0);
    check("t6_cmd_valid", bus.CMD_VALID, 0);
    bus.EN = 1'b1;
    idle(10);
    check("t6_no_cmd_b", cmd_log.size(), 0);
    check("t6_value_b", bus.VALUE, 0);

    // 6c: a fresh full press still works after reset
    press(3'b001);
    check("t6_fresh_n", cmd_log.size(), 1);
    check("t6_fresh_value", bus.VALUE, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
